pulse_width_meter: RTL and testbench



---
 rtl/pulse_width_meter_pkg.sv | 15 +
 rtl/pulse_width_meter_sat_counter.sv | 41 ++++
 rtl/pulse_width_meter.sv | 140 ++++++++++++++
 tb/tb_pulse_width_meter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pulse_width_meter_pkg.sv
// Shared types and defaults for the pulse width meter slice.
package pulse_width_meter_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    MEAS     = 2'd2
  } pwm_state_e;

  // Default expected width tracks the generator's fixed pulse length.
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_EXP_WIDTH = 10;
  localparam int DEF_PCNT_W    = 16;

endpackage

// File: rtl/pulse_width_meter_sat_counter.sv
// Saturating width counter: load-to-1, increment-enable, sticky saturate flag.
module sat_counter
  import pulse_width_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;
  logic             sat_r;

  // Count register; the flag marks an increment that was blocked at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
      sat_r <= 1'b0;
    end else if (load) begin
      cnt_r <= ONE_C;
      sat_r <= 1'b0;
    end else if (inc) begin
      if (cnt_r == MAX_C) begin
        sat_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + ONE_C;
      end
    end
  end

  assign cnt = cnt_r;
  assign sat = sat_r;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures din high widths, checks them against EXP_WIDTH and hands results
// out through a one-entry valid/ready holding register.
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int PCNT_W    = DEF_PCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              clear,
  output logic              width_valid,
  input  logic              width_ready,
  output logic [CNT_W-1:0]  width_data,
  output logic              err_short,
  output logic              err_long,
  output logic              sat,
  output logic [PCNT_W-1:0] pulse_cnt,
  output logic              overrun,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  EXP_C  = CNT_W'(EXP_WIDTH);
  localparam logic [PCNT_W-1:0] PONE_C = {{(PCNT_W-1){1'b0}}, 1'b1};

  pwm_state_e        state_r, next_state_s;
  logic              load_s, inc_s, done_s, store_s, drop_s, accept_s;
  logic [CNT_W-1:0]  cnt_s;
  logic              cnt_sat_s;

  logic              width_valid_r, err_short_r, err_long_r, sat_r, overrun_r, busy_r;
  logic [CNT_W-1:0]  width_data_r;
  logic [PCNT_W-1:0] pulse_cnt_r;

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .inc  (inc_s),
    .cnt  (cnt_s),
    .sat  (cnt_sat_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= WAIT_LOW;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and counter controls.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    inc_s        = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      WAIT_LOW: begin
        if (!din) next_state_s = IDLE;
        else      next_state_s = WAIT_LOW;
      end
      IDLE: begin
        if (din) begin
          next_state_s = MEAS;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      MEAS: begin
        if (din) begin
          next_state_s = MEAS;
          inc_s        = 1'b1;
        end else begin
          next_state_s = IDLE;
          done_s       = 1'b1;
        end
      end
      default: next_state_s = WAIT_LOW;
    endcase
  end

  assign accept_s = width_valid_r && width_ready;
  assign store_s  = done_s && (!width_valid_r || width_ready);
  assign drop_s   = done_s && width_valid_r && !width_ready;

  // Holding register: a completion may refill it on the same edge it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_valid_r <= 1'b0;
      width_data_r  <= {CNT_W{1'b0}};
      err_short_r   <= 1'b0;
      err_long_r    <= 1'b0;
      sat_r         <= 1'b0;
    end else if (store_s) begin
      width_valid_r <= 1'b1;
      width_data_r  <= cnt_s;
      err_short_r   <= (cnt_s < EXP_C) && !cnt_sat_s;
      err_long_r    <= (cnt_s > EXP_C) || cnt_sat_s;
      sat_r         <= cnt_sat_s;
    end else if (accept_s) begin
      width_valid_r <= 1'b0;
    end
  end

  // Pulse counter, overrun flag and busy; a drop outranks clear on overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_cnt_r <= {PCNT_W{1'b0}};
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (next_state_s == MEAS);
      if (clear) begin
        pulse_cnt_r <= done_s ? PONE_C : {PCNT_W{1'b0}};
      end else if (done_s) begin
        pulse_cnt_r <= pulse_cnt_r + PONE_C;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clear) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign width_valid = width_valid_r;
  assign width_data  = width_data_r;
  assign err_short   = err_short_r;
  assign err_long    = err_long_r;
  assign sat         = sat_r;
  assign pulse_cnt   = pulse_cnt_r;
  assign overrun     = overrun_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter with hand-computed expectations.
module tb_pulse_width_meter;

  logic        clk = 1'b0;
  logic        rst, din, clear, width_ready;
  logic        width_valid, err_short, err_long, sat, overrun, busy;
  logic [7:0]  width_data;
  logic [15:0] pulse_cnt;
  int          total = 0;
  int          bad = 0;

  pulse_width_meter #(.CNT_W(8), .EXP_WIDTH(10), .PCNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .clear       (clear),
    .width_valid (width_valid),
    .width_ready (width_ready),
    .width_data  (width_data),
    .err_short   (err_short),
    .err_long    (err_long),
    .sat         (sat),
    .pulse_cnt   (pulse_cnt),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input int w, input bit es, input bit el, input bit s);
    chk({tag, "_valid"}, 32'(width_valid), 32'd1);
    chk({tag, "_data"}, 32'(width_data), 32'(w));
    chk({tag, "_short"}, 32'(err_short), 32'(es));
    chk({tag, "_long"}, 32'(err_long), 32'(el));
    chk({tag, "_sat"}, 32'(sat), 32'(s));
  endtask

  task automatic accept();
    width_ready = 1'b1;
    tick(1);
    width_ready = 1'b0;
    chk("accept_valid", 32'(width_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; clear = 1'b0; width_ready = 1'b0;
    tick(2);
    chk("rst_valid", 32'(width_valid), 32'd0);
    chk("rst_data", 32'(width_data), 32'd0);
    chk("rst_pcnt", 32'(pulse_cnt), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {29'd0, err_short, err_long, sat}, 32'd0);

    // Exact width
    rst = 1'b0;
    tick(3);
    din = 1'b1;
    tick(10);
    chk("exact_busy", 32'(busy), 32'd1);
    chk("exact_prevalid", 32'(width_valid), 32'd0);
    din = 1'b0;
    tick(1);
    chk_result("exact", 10, 1'b0, 1'b0, 1'b0);
    chk("exact_pcnt", 32'(pulse_cnt), 32'd1);
    chk("exact_busy_end", 32'(busy), 32'd0);
    accept();

    // Short and minimal pulses
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("clr_pcnt", 32'(pulse_cnt), 32'd0);
    din = 1'b1; tick(1);
    din = 1'b0; tick(1);
    chk_result("min", 1, 1'b1, 1'b0, 1'b0);
    accept();
    din = 1'b1; tick(3);
    din = 1'b0; tick(1);
    chk_result("short", 3, 1'b1, 1'b0, 1'b0);
    chk("short_pcnt", 32'(pulse_cnt), 32'd2);
    accept();

    // Saturation
    din = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      chk("sat_busy", 32'(busy), 32'd1);
    end
    din = 1'b0; tick(1);
    chk_result("satur", 255, 1'b0, 1'b1, 1'b1);
    accept();

    // Backpressure
    clear = 1'b1; tick(1); clear = 1'b0;
    din = 1'b1; tick(10);
    din = 1'b0; tick(3);
    din = 1'b1; tick(4);
    din = 1'b0; tick(1);
    chk_result("bp", 10, 1'b0, 1'b0, 1'b0);
    chk("bp_ovr", 32'(overrun), 32'd1);
    chk("bp_pcnt", 32'(pulse_cnt), 32'd2);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("bpclr_ovr", 32'(overrun), 32'd0);
    chk("bpclr_pcnt", 32'(pulse_cnt), 32'd0);
    chk_result("bpclr", 10, 1'b0, 1'b0, 1'b0);

    // Simultaneous accept and completion
    din = 1'b1; tick(5);
    din = 1'b0; width_ready = 1'b1; tick(1);
    width_ready = 1'b0;
    chk_result("simul", 5, 1'b1, 1'b0, 1'b0);
    chk("simul_ovr", 32'(overrun), 32'd0);
    chk("simul_pcnt", 32'(pulse_cnt), 32'd1);

    // Clear coinciding with a dropped completion: set wins, count restarts at 1
    din = 1'b1; tick(2);
    din = 1'b0; clear = 1'b1; tick(1); clear = 1'b0;
    chk("clrdrop_ovr", 32'(overrun), 32'd1);
    chk("clrdrop_pcnt", 32'(pulse_cnt), 32'd1);
    chk_result("clrdrop", 5, 1'b1, 1'b0, 1'b0);
    accept();

    // Clear coinciding with a stored completion
    din = 1'b1; tick(12);
    din = 1'b0; clear = 1'b1; tick(1); clear = 1'b0;
    chk("clrstore_pcnt", 32'(pulse_cnt), 32'd1);
    chk("clrstore_ovr", 32'(overrun), 32'd0);
    chk_result("clrstore", 12, 1'b0, 1'b1, 1'b0);
    accept();

    // Reset mid-pulse
    din = 1'b1; tick(3);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pcnt", 32'(pulse_cnt), 32'd0);
    tick(6);
    chk("mid_hold_busy", 32'(busy), 32'd0);
    din = 1'b0; tick(2);
    chk("mid_noresult", 32'(width_valid), 32'd0);
    chk("mid_nocount", 32'(pulse_cnt), 32'd0);
    din = 1'b1; tick(10);
    din = 1'b0; tick(1);
    chk_result("mid", 10, 1'b0, 1'b0, 1'b0);
    chk("mid_pcnt", 32'(pulse_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
